// File: rtl/local_packetizer.sv
// rtl/local_packetizer.sv - frames core messages into header/body/tail flits for a router local port
module local_packetizer #(
    parameter int ROUTER_ID = 4,
    parameter int MAX_LEN   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [3:0]  msg_dest_i,
    input  logic [2:0]  msg_len_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic [13:0] word_data_i,
    input  logic        local_full_i,
    output logic [16:0] local_data_o,
    output logic        busy_o,
    output logic [7:0]  pkt_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    localparam logic [3:0] SRC_ID  = 4'(ROUTER_ID);
    localparam logic [2:0] LEN_CAP = 3'(MAX_LEN);

    state_t      state;
    logic [3:0]  dest_q;
    logic [2:0]  len_q;
    logic [2:0]  remaining;
    logic [16:0] flit_q;
    logic [7:0]  pkt_count_q;

    // Ready is gated by rst so it reads 0 while reset is held, 1 as soon as it lifts.
    assign msg_ready_o  = (state == IDLE) & rst;
    assign word_ready_o = (state == BODY) & word_valid_i & ~local_full_i;
    assign busy_o       = (state != IDLE);
    assign local_data_o = flit_q;
    assign pkt_count_o  = pkt_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dest_q      <= '0;
            len_q       <= '0;
            remaining   <= '0;
            flit_q      <= '0;
            pkt_count_q <= '0;
        end else begin
            // Flit register is cleared every cycle so a flit is visible for exactly one cycle.
            flit_q <= '0;
            case (state)
                IDLE: begin
                    if (msg_valid_i) begin
                        dest_q <= msg_dest_i;
                        len_q  <= (msg_len_i > LEN_CAP) ? LEN_CAP : msg_len_i;
                        state  <= HEAD;
                    end
                end
                HEAD: begin
                    if (!local_full_i) begin
                        flit_q <= {1'b1, 1'b1, (len_q == 3'd0), dest_q, SRC_ID, len_q, 3'b000};
                        if (len_q == 3'd0) begin
                            state       <= IDLE;
                            pkt_count_q <= pkt_count_q + 8'd1;
                        end else begin
                            state     <= BODY;
                            remaining <= len_q;
                        end
                    end
                end
                BODY: begin
                    if (word_ready_o) begin
                        flit_q    <= {1'b1, 1'b0, (remaining == 3'd1), word_data_i};
                        remaining <= remaining - 3'd1;
                        if (remaining == 3'd1) begin
                            state       <= IDLE;
                            pkt_count_q <= pkt_count_q + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
